// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - round-robin select sequencer for the 4-to-1 channel mux
// Optional build macro: MUX_SEL_FIXED_PRIO_EN (fixed priority, channel 0 highest)
module mux_sel_scanner #(
    parameter int DWELL_W = 4
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iEn,
    input  logic [3:0]         iReq,
    input  logic [DWELL_W-1:0] iDwell,
    input  logic               iReady,
    output logic [1:0]         oSel,
    output logic [3:0]         oGrant,
    output logic               oValid,
    output logic               oSwitch
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [3:0]         r_grant;
    logic               r_valid;
    logic               r_switch;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_ptr;

    state_t             w_state_nxt;
    logic [1:0]         w_sel_nxt;
    logic [3:0]         w_grant_nxt;
    logic               w_valid_nxt;
    logic               w_switch_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [1:0]         w_ptr_nxt;

    logic [1:0]         w_start;
    logic [1:0]         w_idx;
    logic [1:0]         w_pick;
    logic               w_found;
    logic               w_load;
    logic [DWELL_W-1:0] w_dwell_load;

`ifdef MUX_SEL_FIXED_PRIO_EN
    assign w_start = 2'd0;
`else
    // The current owner is the last candidate, so a sole requester is re-granted.
    assign w_start = r_ptr + 2'd1;
`endif

    // A dwell of zero would never expire; treat it as a single transfer.
    assign w_dwell_load = (iDwell == '0) ? DWELL_W'(1) : iDwell;

    // Circular search for the first requesting channel starting at w_start.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = w_start + 2'(i);
            if (!w_found && iReq[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Next-state and next-output decode; abort outranks the last transfer.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_grant_nxt  = r_grant;
        w_valid_nxt  = r_valid;
        w_switch_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                w_grant_nxt = 4'b0000;
                w_load      = iEn && w_found;
            end
            S_HOLD: begin
                if (!iEn || !iReq[r_sel]) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_grant_nxt = 4'b0000;
                end else if (iReady) begin
                    if (r_cnt <= DWELL_W'(1)) begin
                        if (w_found) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                            w_grant_nxt = 4'b0000;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - DWELL_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_grant_nxt = 4'b0000;
            end
        endcase

        if (w_load) begin
            w_state_nxt  = S_HOLD;
            w_sel_nxt    = w_pick;
            w_grant_nxt  = 4'b0001 << w_pick;
            w_valid_nxt  = 1'b1;
            w_switch_nxt = 1'b1;
            w_cnt_nxt    = w_dwell_load;
            w_ptr_nxt    = w_pick;
        end
    end

    // State and registered outputs; reset clears outputs immediately.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'd0;
            r_grant  <= 4'b0000;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= 2'd3;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_grant  <= w_grant_nxt;
            r_valid  <= w_valid_nxt;
            r_switch <= w_switch_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign oSel    = r_sel;
    assign oGrant  = r_grant;
    assign oValid  = r_valid;
    assign oSwitch = r_switch;

endmodule
